err_addr_logger: RTL and testbench

- Pipelined read-data checker for the 64-bit test datapath.
- On each enabled read it compares returned data against expected data. A mismatch logs the read address and the number of flipped bits into a show-ahead FIFO, and updates error statistics.
- Sits between the memory read port and the test controller. The controller drains the FIFO at its own pace.

---
 rtl/err_addr_logger.sv | 167 ++++++++++++++++
 tb/tb_err_addr_logger.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/err_addr_logger.sv
`default_nettype none
// ============================================================================
// Module   : err_addr_logger
// Purpose  : Pipelined read-data checker. Each enabled read compares the
//            returned data with the expected data. A mismatch logs
//            {address, flipped-bit count} into a show-ahead FIFO and updates
//            the error statistics (saturating count, first-error address,
//            sticky overflow).
// Ports    : clk, rst (async, active-high), clr (sync clear)
//            R_EN / R_ADDR / real_data / wrong_real_data : compare request
//            pop                                         : consume FIFO head
//            err_valid / err_addr / err_bits / fifo_level: FIFO head/status
//            err_cnt / first_valid / first_addr / overflow: statistics
// Revision : 1.0 - initial release
// ============================================================================
module err_addr_logger #(
  parameter  int DATA_W = 64,
  parameter  int ADDR_W = 14,
  parameter  int DEPTH  = 16,
  parameter  int CNT_W  = 16,
  localparam int BC_W   = $clog2(DATA_W + 1),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              R_EN,
  input  logic [ADDR_W-1:0] R_ADDR,
  input  logic [DATA_W-1:0] real_data,
  input  logic [DATA_W-1:0] wrong_real_data,
  input  logic              pop,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [BC_W-1:0]   err_bits,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_valid,
  output logic [ADDR_W-1:0] first_addr,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + BC_W;

  // Stage 1: captured request and raw difference vector
  logic              s1_v_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s1_x_q;

  // Stage 2: qualified mismatch and its bit count
  logic              s2_v_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [BC_W-1:0]   s2_bc_q;
  logic [BC_W-1:0]   s1_bc_d;

  // FIFO state
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;

  // Statistics
  logic [CNT_W-1:0]  err_cnt_q;
  logic              first_valid_q;
  logic [ADDR_W-1:0] first_addr_q;
  logic              overflow_q;

  logic              do_pop;
  logic              do_push;
  logic              full_after_pop;
  logic [ENT_W-1:0]  head;

  always_comb begin
    s1_bc_d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      s1_bc_d = s1_bc_d + BC_W'(s1_x_q[i]);
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_pop         = pop && (level_q != '0);
  assign full_after_pop = (level_q == LVL_W'(DEPTH)) && !do_pop;
  assign do_push        = s2_v_q && !full_after_pop;
  assign level_d        = level_q + LVL_W'(do_push) - LVL_W'(do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q        <= 1'b0;
      s1_addr_q     <= '0;
      s1_x_q        <= '0;
      s2_v_q        <= 1'b0;
      s2_addr_q     <= '0;
      s2_bc_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      err_cnt_q     <= '0;
      first_valid_q <= 1'b0;
      first_addr_q  <= '0;
      overflow_q    <= 1'b0;
    end else if (clr) begin
      s1_v_q        <= 1'b0;
      s1_addr_q     <= '0;
      s1_x_q        <= '0;
      s2_v_q        <= 1'b0;
      s2_addr_q     <= '0;
      s2_bc_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      err_cnt_q     <= '0;
      first_valid_q <= 1'b0;
      first_addr_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      s1_v_q    <= R_EN;
      s1_addr_q <= R_ADDR;
      s1_x_q    <= real_data ^ wrong_real_data;

      s2_v_q    <= s1_v_q && (s1_x_q != '0);
      s2_addr_q <= s1_addr_q;
      s2_bc_q   <= s1_bc_d;

      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q <= level_d;

      if (s2_v_q) begin
        if (err_cnt_q != {CNT_W{1'b1}}) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
        if (!first_valid_q) begin
          first_valid_q <= 1'b1;
          first_addr_q  <= s2_addr_q;
        end
        if (full_after_pop) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  // Storage array needs no reset; the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= {s2_addr_q, s2_bc_q};
    end
  end

  // Head fields are forced to zero while empty so every output reads 0 after reset.
  assign head        = mem_q[rd_ptr_q];
  assign err_valid   = (level_q != '0);
  assign err_addr    = err_valid ? head[ENT_W-1:BC_W] : '0;
  assign err_bits    = err_valid ? head[BC_W-1:0]     : '0;
  assign fifo_level  = level_q;
  assign err_cnt     = err_cnt_q;
  assign first_valid = first_valid_q;
  assign first_addr  = first_addr_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_err_addr_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_err_addr_logger
// Purpose  : Self-checking bench for err_addr_logger (DEPTH=4, CNT_W=3).
//            An event-scheduled reference model predicts every output each
//            cycle; directed sequences add hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_err_addr_logger;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int BC_W   = $clog2(DATA_W + 1);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              R_EN = 1'b0;
  logic [ADDR_W-1:0] R_ADDR = '0;
  logic [DATA_W-1:0] real_data = '0;
  logic [DATA_W-1:0] wrong_real_data = '0;
  logic              pop = 1'b0;
  logic              err_valid;
  logic [ADDR_W-1:0] err_addr;
  logic [BC_W-1:0]   err_bits;
  logic [LVL_W-1:0]  fifo_level;
  logic [CNT_W-1:0]  err_cnt;
  logic              first_valid;
  logic [ADDR_W-1:0] first_addr;
  logic              overflow;

  err_addr_logger #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .clr             (clr),
    .R_EN            (R_EN),
    .R_ADDR          (R_ADDR),
    .real_data       (real_data),
    .wrong_real_data (wrong_real_data),
    .pop             (pop),
    .err_valid       (err_valid),
    .err_addr        (err_addr),
    .err_bits        (err_bits),
    .fifo_level      (fifo_level),
    .err_cnt         (err_cnt),
    .first_valid     (first_valid),
    .first_addr      (first_addr),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: a mismatch sampled at edge n is committed at edge n+2.
  // ------------------------------------------------------------------
  typedef struct {
    int              due;
    logic [ADDR_W-1:0] a;
    int              bits;
  } ev_t;

  typedef struct {
    logic [ADDR_W-1:0] a;
    int              bits;
  } ent_t;

  ev_t               pend[$];
  ent_t              mq[$];
  int                m_cnt = 0;
  bit                m_fv  = 1'b0;
  logic [ADDR_W-1:0] m_fa  = '0;
  bit                m_ovf = 1'b0;
  int                edge_n = 0;

  task automatic model_clear();
    pend.delete();
    mq.delete();
    m_cnt = 0;
    m_fv  = 1'b0;
    m_fa  = '0;
    m_ovf = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear();
    end else begin
      edge_n++;
      if (clr) begin
        model_clear();
      end else begin
        if (pop && mq.size() > 0) void'(mq.pop_front());
        while (pend.size() > 0 && pend[0].due == edge_n) begin
          ev_t e;
          e = pend.pop_front();
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!m_fv) begin
            m_fv = 1'b1;
            m_fa = e.a;
          end
          if (mq.size() < DEPTH) mq.push_back('{a: e.a, bits: e.bits});
          else m_ovf = 1'b1;
        end
        if (R_EN && (real_data != wrong_real_data)) begin
          pend.push_back('{due: edge_n + 2, a: R_ADDR,
                           bits: $countones(real_data ^ wrong_real_data)});
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_err_valid",   err_valid,   (mq.size() != 0));
    chk("m_fifo_level",  fifo_level,  mq.size());
    chk("m_err_cnt",     err_cnt,     m_cnt);
    chk("m_first_valid", first_valid, m_fv);
    chk("m_first_addr",  first_addr,  m_fa);
    chk("m_overflow",    overflow,    m_ovf);
    if (mq.size() != 0) begin
      chk("m_err_addr", err_addr, mq[0].a);
      chk("m_err_bits", err_bits, mq[0].bits);
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic cyc(input logic en, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] ed,
                     input logic p, input logic c);
    @(negedge clk);
    R_EN = en; R_ADDR = a; real_data = rd; wrong_real_data = ed; pop = p; clr = c;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] ones;
    logic [ADDR_W-1:0] exp_head [4];
    ones = '1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle with matching data
    for (int i = 0; i < 10; i++) cyc(1'b1, ADDR_W'(i), 64'hDEAD_BEEF + i, 64'hDEAD_BEEF + i, 1'b0, 1'b0);
    idle(); idle(); idle();
    settle();
    chk("idle_valid", err_valid, 0);
    chk("idle_cnt",   err_cnt,   0);
    chk("idle_first", first_valid, 0);

    // Single mismatch, 3-edge latency
    cyc(1'b1, 14'h0123, 64'h0, 64'h5, 1'b0, 1'b0);
    idle(); idle();
    settle();
    chk("single_valid", err_valid, 1);
    chk("single_addr",  err_addr,  14'h0123);
    chk("single_bits",  err_bits,  2);
    chk("single_cnt",   err_cnt,   1);
    chk("single_first", first_addr, 14'h0123);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    settle();
    chk("pop_valid", err_valid, 0);
    chk("pop_first", first_addr, 14'h0123);
    chk("pop_fv",    first_valid, 1);

    // R_EN low with differing data has no effect
    cyc(1'b0, 14'h0777, ones, '0, 1'b0, 1'b0);
    idle(); idle(); idle();
    settle();
    chk("noen_cnt",   err_cnt,    1);
    chk("noen_level", fifo_level, 0);

    // Six back-to-back mismatches into a 4-deep FIFO
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int a = 1; a <= 6; a++) cyc(1'b1, ADDR_W'(a), '0, DATA_W'(a), 1'b0, 1'b0);
    idle(); idle();
    settle();
    chk("six_level", fifo_level, 4);
    chk("six_ovf",   overflow,   1);
    chk("six_cnt",   err_cnt,    6);
    chk("six_first", first_addr, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("six_order", err_addr, k);
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
      settle();
    end
    chk("six_drained", fifo_level, 0);

    // Full FIFO: simultaneous push and pop must not overflow
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int a = 1; a <= 4; a++) cyc(1'b1, ADDR_W'(a), '0, DATA_W'(a), 1'b0, 1'b0);
    idle(); idle();
    settle();
    chk("full_level", fifo_level, 4);
    chk("full_ovf",   overflow,   0);
    cyc(1'b1, 14'd5, '0, 64'd5, 1'b0, 1'b0);
    idle();
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    settle();
    chk("pp_level", fifo_level, 4);
    chk("pp_ovf",   overflow,   0);
    chk("pp_head",  err_addr,   2);
    cyc(1'b1, 14'd6, '0, 64'd6, 1'b0, 1'b0);
    idle(); idle();
    settle();
    chk("drop_ovf",  overflow, 1);
    chk("drop_cnt",  err_cnt,  6);
    exp_head[0] = 14'd2; exp_head[1] = 14'd3; exp_head[2] = 14'd4; exp_head[3] = 14'd5;
    for (int k = 0; k < 4; k++) begin
      chk("pp_order", err_addr, exp_head[k]);
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
      settle();
    end

    // Bit-count extremes
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cyc(1'b1, 14'h3FFF, ones, '0, 1'b0, 1'b0);
    cyc(1'b1, 14'h2000, 64'h8000_0000_0000_0000, '0, 1'b0, 1'b0);
    idle();
    settle();
    chk("bc64_addr", err_addr, 14'h3FFF);
    chk("bc64_bits", err_bits, 64);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    settle();
    chk("bc1_addr", err_addr, 14'h2000);
    chk("bc1_bits", err_bits, 1);

    // Counter saturation, then clr with a mismatch on the clr cycle
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, ADDR_W'(14'h100 + i), DATA_W'(i + 1), '0, 1'b1, 1'b0);
    idle(); idle();
    settle();
    chk("sat_cnt",   err_cnt,    CNT_MAX);
    chk("sat_first", first_addr, 14'h100);
    cyc(1'b1, 14'h0055, 64'h1, '0, 1'b0, 1'b1);
    settle();
    chk("clr_cnt",   err_cnt,     0);
    chk("clr_fv",    first_valid, 0);
    chk("clr_level", fifo_level,  0);
    idle(); idle(); idle();
    settle();
    chk("clr_drop_valid", err_valid, 0);
    chk("clr_drop_cnt",   err_cnt,   0);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) cyc(1'b1, ADDR_W'(14'h200 + i), '0, DATA_W'(i + 1), 1'b0, 1'b0);
    #2;
    chk("pre_rst_cnt", err_cnt, 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", err_valid,   0);
    chk("arst_cnt",   err_cnt,     0);
    chk("arst_fv",    first_valid, 0);
    chk("arst_level", fifo_level,  0);
    idle();
    idle();
    rst = 1'b0;
    cyc(1'b1, 14'h02AA, '0, 64'h3, 1'b0, 1'b0);
    idle(); idle();
    settle();
    chk("post_rst_first", first_addr,  14'h02AA);
    chk("post_rst_fv",    first_valid, 1);
    chk("post_rst_cnt",   err_cnt,     1);
    chk("post_rst_bits",  err_bits,    2);

    idle(); idle();
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
